// File: rtl/clk_sel_sync_pkg.sv
// Shared types and default parameter values for the glitch-free game-speed clock selector.
package clk_sel_sync_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ARM   = 2'd2
  } state_t;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_SEL_W       = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 1023;

endpackage

// File: rtl/clk_sel_sync_sync_ff.sv
// Multi-flop synchroniser bringing WIDTH asynchronous source clocks into the system clock domain.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  // NOTE: the whole chain is reset so the selected level reads a defined 0 straight out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '0;
    end else begin
      // NOTE: non-blocking assignment makes every stage sample the previous stage's old value.
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/clk_sel_sync.sv
// Glitch-free N_CH:1 game-speed clock selector: synchronised sources, safe-low switching with a
// timeout fallback, registered CLKHZ plus a one-cycle tick on each CLKHZ rising edge.
module clk_sel_sync
  import clk_sel_sync_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [SEL_W-1:0] level,
  input  logic [N_CH-1:0]  CL,
  output logic             CLKHZ,
  output logic             tick,
  output logic [SEL_W-1:0] cur_level,
  output logic             busy,
  output logic             sw_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [N_CH-1:0]  s;
  state_t           state, state_nxt;
  logic [SEL_W-1:0] target, target_nxt, cur_nxt;
  logic [TMR_W-1:0] timer, timer_nxt, timer_inc;
  logic             clk_nxt, err_nxt;
  logic             cur_src, tgt_src, level_ok, timeout;

  sync_ff #(.WIDTH(N_CH), .STAGES(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (CL),
    .q       (s)
  );

  // Requests beyond the populated sources are treated as no request at all.
  assign level_ok  = ({1'b0, level} < (SEL_W + 1)'(N_CH));
  assign timer_inc = timer + TMR_W'(1);
  assign timeout   = (timer_inc == TMR_W'(TIMEOUT));

  always_comb begin
    cur_src = 1'b0;
    tgt_src = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cur_level == SEL_W'(i)) cur_src = s[i];
      if (target == SEL_W'(i))    tgt_src = s[i];
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    timer_nxt  = timer_inc;
    cur_nxt    = cur_level;
    clk_nxt    = cur_src;
    err_nxt    = sw_err;
    unique case (state)
      ST_RUN: begin
        timer_nxt = '0;
        if (level_ok && level != cur_level) begin
          target_nxt = level;
          state_nxt  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (level == cur_level) begin
          state_nxt = ST_RUN;
          timer_nxt = '0;
        end else begin
          if (level_ok) target_nxt = level;
          // Old source low (or stuck high too long): park CLKHZ low and wait on the new one.
          if (!cur_src || timeout) begin
            state_nxt = ST_ARM;
            timer_nxt = '0;
            clk_nxt   = 1'b0;
          end
        end
      end
      ST_ARM: begin
        clk_nxt = 1'b0;
        if (level_ok && level != target) begin
          target_nxt = level;
          timer_nxt  = '0;
        end else if (!tgt_src || timeout) begin
          cur_nxt   = target;
          state_nxt = ST_RUN;
          timer_nxt = '0;
          if (tgt_src) err_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      target    <= '0;
      timer     <= '0;
      cur_level <= '0;
      CLKHZ     <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
      sw_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      timer     <= timer_nxt;
      cur_level <= cur_nxt;
      CLKHZ     <= clk_nxt;
      tick      <= clk_nxt & ~CLKHZ;
      busy      <= (state_nxt != ST_RUN);
      sw_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_clk_sel_sync.sv
// Directed bench for clk_sel_sync: follow, safe switch, abort, retarget, timeout, reset, invalid level.
module tb_clk_sel_sync;

  logic       clock;
  logic       reset_n;
  logic [1:0] level;
  logic [3:0] CL;

  logic       a_clkhz, a_tick, a_busy, a_err;
  logic [1:0] a_cur;
  logic       t_clkhz, t_tick, t_busy, t_err;
  logic [1:0] t_cur;
  logic       c_clkhz, c_tick, c_busy, c_err;
  logic [1:0] c_cur;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt     = 0;
  int mode   [4];
  int period [4];
  int phase  [4];
  logic [3:0] hist [4096];

  clk_sel_sync dut_a (
    .clock(clock), .reset_n(reset_n), .level(level), .CL(CL),
    .CLKHZ(a_clkhz), .tick(a_tick), .cur_level(a_cur), .busy(a_busy), .sw_err(a_err)
  );

  clk_sel_sync #(.N_CH(4), .SEL_W(2), .SYNC_STAGES(2), .TIMEOUT(15)) dut_t (
    .clock(clock), .reset_n(reset_n), .level(level), .CL(CL),
    .CLKHZ(t_clkhz), .tick(t_tick), .cur_level(t_cur), .busy(t_busy), .sw_err(t_err)
  );

  clk_sel_sync #(.N_CH(3), .SEL_W(2)) dut_c (
    .clock(clock), .reset_n(reset_n), .level(level), .CL(CL[2:0]),
    .CLKHZ(c_clkhz), .tick(c_tick), .cur_level(c_cur), .busy(c_busy), .sw_err(c_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock: sample point is 1 time unit after the edge, then sources advance.
  task automatic step();
    @(posedge clock);
    #1;
    cnt++;
    for (int i = 0; i < 4; i++) begin
      case (mode[i])
        0:       CL[i] = 1'b0;
        1:       CL[i] = 1'b1;
        default: CL[i] = ((cnt + phase[i]) % period[i]) < (period[i] / 2);
      endcase
    end
    hist[cnt % 4096] = CL;
  endtask

  task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
    mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
    for (int i = 0; i < 4; i++) begin
      period[i] = 20;
      phase[i]  = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    level   = 2'd0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({a_clkhz, a_tick, a_cur, a_busy, a_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_a: got %b expected 000000", {a_clkhz, a_tick, a_cur, a_busy, a_err});
    end
    n_tests++;
    if ({t_clkhz, t_tick, t_cur, t_busy, t_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_t: got %b expected 000000", {t_clkhz, t_tick, t_cur, t_busy, t_err});
    end
    n_tests++;
    if ({c_clkhz, c_tick, c_cur, c_busy, c_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_c: got %b expected 000000", {c_clkhz, c_tick, c_cur, c_busy, c_err});
    end
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_follow();
    int mism = 0, tick_bad = 0, busy_bad = 0, rises = 0;
    logic prev;
    logic [3:0] h;
    set_modes(2, 0, 0, 0);
    level = 2'd0;
    repeat (10) step();
    prev = a_clkhz;
    for (int k = 0; k < 60; k++) begin
      step();
      h = hist[(cnt - 3) % 4096];
      if (a_clkhz !== h[0]) mism++;
      if (a_tick !== (a_clkhz & ~prev)) tick_bad++;
      if (a_tick === 1'b1) rises++;
      if (a_busy !== 1'b0) busy_bad++;
      prev = a_clkhz;
    end
    n_tests++;
    if (mism != 0) begin n_fail++; $display("FAIL follow_lag3: %0d cycles differ, expected 0", mism); end
    n_tests++;
    if (tick_bad != 0) begin n_fail++; $display("FAIL follow_tick: %0d bad tick cycles, expected 0", tick_bad); end
    n_tests++;
    if (rises != 3) begin n_fail++; $display("FAIL follow_tick_count: got %0d expected 3", rises); end
    n_tests++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL follow_busy: %0d busy cycles, expected 0", busy_bad); end
  endtask

  task automatic test_switch();
    logic       r_clk  [0:40];
    logic       r_busy [0:40];
    logic       r_tick [0:40];
    logic [1:0] r_cur  [0:40];
    int min_run = 1000, runs = 0, last_edge = -1;
    mode[2] = 2; period[2] = 20; phase[2] = 15;   // CL2 high for cnt%20 in 5..14
    while (cnt % 20 != 6) step();
    r_clk[6] = a_clkhz; r_busy[6] = a_busy; r_tick[6] = a_tick; r_cur[6] = a_cur;
    level = 2'd2;
    for (int k = 7; k <= 40; k++) begin
      step();
      r_clk[k] = a_clkhz; r_busy[k] = a_busy; r_tick[k] = a_tick; r_cur[k] = a_cur;
    end
    n_tests++;
    if (r_busy[6] !== 1'b0 || r_busy[7] !== 1'b1) begin
      n_fail++; $display("FAIL switch_busy_rise: got %b%b expected 01", r_busy[6], r_busy[7]);
    end
    n_tests++;
    if (r_clk[12] !== 1'b1 || r_clk[13] !== 1'b0) begin
      n_fail++; $display("FAIL switch_drain_fall: got %b%b expected 10", r_clk[12], r_clk[13]);
    end
    n_tests++;
    if (r_cur[17] !== 2'd0 || r_busy[17] !== 1'b1) begin
      n_fail++; $display("FAIL switch_pre_commit: cur %0d busy %b expected cur 0 busy 1", r_cur[17], r_busy[17]);
    end
    n_tests++;
    if (r_cur[18] !== 2'd2 || r_busy[18] !== 1'b0) begin
      n_fail++; $display("FAIL switch_commit: cur %0d busy %b expected cur 2 busy 0", r_cur[18], r_busy[18]);
    end
    n_tests++;
    if (r_clk[27] !== 1'b0 || r_clk[28] !== 1'b1 || r_tick[28] !== 1'b1) begin
      n_fail++; $display("FAIL switch_new_rise: clk %b%b tick %b expected 01 tick 1", r_clk[27], r_clk[28], r_tick[28]);
    end
    for (int k = 7; k <= 40; k++) begin
      if (r_clk[k] !== r_clk[k-1]) begin
        if (last_edge >= 0) begin
          runs++;
          if (k - last_edge < min_run) min_run = k - last_edge;
        end
        last_edge = k;
      end
    end
    n_tests++;
    if (runs < 2 || min_run < 10) begin
      n_fail++; $display("FAIL switch_min_pulse: %0d runs, shortest %0d, expected >=2 runs of >=10", runs, min_run);
    end
  endtask

  task automatic test_abort();
    int mism = 0, cur_bad = 0;
    logic b2, b3, b4, b5;
    logic [3:0] h;
    set_modes(2, 0, 0, 0);
    do_reset();
    repeat (10) step();
    while (cnt % 20 != 2) step();
    b2 = a_busy;
    level = 2'd1;
    for (int k = 3; k <= 42; k++) begin
      step();
      h = hist[(cnt - 3) % 4096];
      if (a_clkhz !== h[0]) mism++;
      if (a_cur !== 2'd0) cur_bad++;
      if (k == 3) b3 = a_busy;
      if (k == 4) begin
        b4 = a_busy;
        level = 2'd0;
      end
      if (k == 5) b5 = a_busy;
    end
    n_tests++;
    if ({b2, b3, b4, b5} !== 4'b0110) begin
      n_fail++; $display("FAIL abort_busy: got %b expected 0110", {b2, b3, b4, b5});
    end
    n_tests++;
    if (mism != 0) begin n_fail++; $display("FAIL abort_waveform: %0d cycles differ, expected 0", mism); end
    n_tests++;
    if (cur_bad != 0) begin n_fail++; $display("FAIL abort_cur: %0d cycles cur!=0, expected 0", cur_bad); end
  endtask

  task automatic test_retarget();
    logic       r_busy [0:30];
    logic       r_err  [0:30];
    logic [1:0] r_cur  [0:30];
    int glitch = 0;
    set_modes(0, 0, 1, 1);
    do_reset();
    repeat (5) step();
    level = 2'd2;
    for (int k = 1; k <= 30; k++) begin
      step();
      r_busy[k] = t_busy; r_err[k] = t_err; r_cur[k] = t_cur;
      if (t_clkhz !== 1'b0 || t_tick !== 1'b0) glitch++;
      if (k == 10) level = 2'd3;
      if (k == 20) level = 2'd1;
    end
    n_tests++;
    if (r_busy[1] !== 1'b1 || r_busy[17] !== 1'b1 || r_err[17] !== 1'b0) begin
      n_fail++; $display("FAIL retarget_timer_restart: busy %b/%b err %b expected 1/1 err 0", r_busy[1], r_busy[17], r_err[17]);
    end
    n_tests++;
    if (r_busy[21] !== 1'b1 || r_cur[21] !== 2'd0) begin
      n_fail++; $display("FAIL retarget_pre_commit: busy %b cur %0d expected busy 1 cur 0", r_busy[21], r_cur[21]);
    end
    n_tests++;
    if (r_busy[22] !== 1'b0 || r_cur[22] !== 2'd1 || r_err[30] !== 1'b0) begin
      n_fail++; $display("FAIL retarget_commit: busy %b cur %0d err %b expected busy 0 cur 1 err 0", r_busy[22], r_cur[22], r_err[30]);
    end
    n_tests++;
    if (glitch != 0) begin n_fail++; $display("FAIL retarget_glitch: %0d cycles with CLKHZ/tick high, expected 0", glitch); end
  endtask

  task automatic test_timeout();
    logic       r_busy [0:40];
    logic       r_err  [0:40];
    logic       r_clk  [0:40];
    logic       r_tick [0:40];
    logic [1:0] r_cur  [0:40];
    int busy_cnt = 0, after_bad = 0;
    set_modes(0, 0, 0, 1);
    do_reset();
    repeat (5) step();
    level = 2'd3;
    for (int k = 1; k <= 40; k++) begin
      step();
      r_busy[k] = t_busy; r_err[k] = t_err; r_clk[k] = t_clkhz; r_tick[k] = t_tick; r_cur[k] = t_cur;
      if (t_busy === 1'b1) busy_cnt++;
    end
    for (int k = 19; k <= 40; k++) begin
      if (r_clk[k] !== 1'b1 || r_tick[k] !== 1'b0 || r_err[k] !== 1'b1) after_bad++;
    end
    n_tests++;
    if (busy_cnt != 16 || r_busy[16] !== 1'b1 || r_busy[17] !== 1'b0) begin
      n_fail++; $display("FAIL timeout_busy: %0d busy cycles, busy16 %b busy17 %b expected 16,1,0", busy_cnt, r_busy[16], r_busy[17]);
    end
    n_tests++;
    if (r_err[16] !== 1'b0 || r_err[17] !== 1'b1 || r_cur[17] !== 2'd3) begin
      n_fail++; $display("FAIL timeout_commit: err %b%b cur %0d expected err 01 cur 3", r_err[16], r_err[17], r_cur[17]);
    end
    n_tests++;
    if (r_clk[17] !== 1'b0 || r_clk[18] !== 1'b1) begin
      n_fail++; $display("FAIL timeout_clkhz: got %b%b expected 01", r_clk[17], r_clk[18]);
    end
    n_tests++;
    if (after_bad != 0) begin n_fail++; $display("FAIL timeout_steady: %0d bad cycles after commit, expected 0", after_bad); end
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    set_modes(2, 0, 1, 0);
    do_reset();
    repeat (10) step();
    while (cnt % 20 != 2) step();
    level = 2'd2;
    repeat (14) step();
    n_tests++;
    if (a_busy !== 1'b1 || a_clkhz !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_in_arm: busy %b clk %b expected busy 1 clk 0", a_busy, a_clkhz);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({a_clkhz, a_tick, a_cur, a_busy, a_err} !== 6'b0) begin
      n_fail++; $display("FAIL rstmid_async: got %b expected 000000", {a_clkhz, a_tick, a_cur, a_busy, a_err});
    end
    mode[2] = 0;
    #1 reset_n = 1'b1;
    #1;
    n_tests++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_released: busy %b expected 0", a_busy); end
    step();
    n_tests++;
    if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart: busy %b expected 1", a_busy); end
    while (a_cur !== 2'd2 && waited < 30) begin
      step();
      waited++;
    end
    n_tests++;
    if (a_cur !== 2'd2) begin n_fail++; $display("FAIL rstmid_commit: cur %0d expected 2 within 30 cycles", a_cur); end
  endtask

  task automatic test_invalid();
    int busy_bad = 0, cur_bad = 0;
    set_modes(2, 0, 0, 1);
    do_reset();
    level = 2'd3;
    repeat (12) begin
      step();
      if (c_busy !== 1'b0) busy_bad++;
      if (c_cur !== 2'd0) cur_bad++;
    end
    n_tests++;
    if (busy_bad != 0) begin n_fail++; $display("FAIL invalid_busy: %0d busy cycles, expected 0", busy_bad); end
    n_tests++;
    if (cur_bad != 0) begin n_fail++; $display("FAIL invalid_cur: %0d cycles cur!=0, expected 0", cur_bad); end
  endtask

  initial begin
    reset_n = 1'b1;
    level   = 2'd0;
    CL      = 4'd0;
    set_modes(0, 0, 0, 0);
    test_reset();
    test_follow();
    test_switch();
    test_abort();
    test_retarget();
    test_timeout();
    test_reset_mid();
    test_invalid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
